// File: rtl/framebuffer_pkg.sv
// Shared framebuffer geometry, FSM state encoding and address helpers.
// Contents: screen size, coordinate widths, fill FSM states, row-base and legality functions.
package framebuffer_pkg;

    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int FB_DEPTH = 19200;
    localparam int X_WIDTH  = 8;
    localparam int Y_WIDTH  = 7;
    localparam int FB_AW    = 15;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;

    // y*160 built as y*128 + y*32 so no multiplier is inferred.
    function automatic logic [FB_AW-1:0] row_base(
        input logic [Y_WIDTH-1:0] y
    );
        logic [FB_AW-1:0] ye;
        ye = {{(FB_AW-Y_WIDTH){1'b0}}, y};
        return (ye << 7) + (ye << 5);
    endfunction

    function automatic logic cmd_legal(
        input logic [X_WIDTH-1:0] x0,
        input logic [Y_WIDTH-1:0] y0,
        input logic [X_WIDTH-1:0] x1,
        input logic [Y_WIDTH-1:0] y1
    );
        return (x0 <= x1) && (y0 <= y1) &&
               (x1 <= X_WIDTH'(H_RES - 1)) &&
               (y1 <= Y_WIDTH'(V_RES - 1));
    endfunction

endpackage

// File: rtl/framebuffer_fill_ctrl.sv
// Rectangle fill engine: writes one pixel per cycle in raster order into the framebuffer.
// Ports: write_clock/reset_n, cmd_* handshake + rectangle, busy/done/err status, write_addr/data/we write port.
module framebuffer_fill_ctrl
    import framebuffer_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  write_clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [X_WIDTH-1:0]    cmd_x0,
    input  logic [Y_WIDTH-1:0]    cmd_y0,
    input  logic [X_WIDTH-1:0]    cmd_x1,
    input  logic [Y_WIDTH-1:0]    cmd_y1,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  we
);

    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(H_RES);

    fill_state_t            state;
    logic [X_WIDTH-1:0]     x0_q;
    logic [X_WIDTH-1:0]     x1_q;
    logic [Y_WIDTH-1:0]     y1_q;
    logic [X_WIDTH-1:0]     cur_x;
    logic [Y_WIDTH-1:0]     cur_y;
    logic [FB_AW-1:0]       row_q;
    logic [FB_AW-1:0]       addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   we_q;
    logic                   done_q;
    logic                   err_q;

    logic                   legal;
    logic                   last_px;
    logic                   row_end;
    logic [FB_AW-1:0]       first_row;
    logic [FB_AW-1:0]       next_row;

    assign legal     = cmd_legal(cmd_x0, cmd_y0, cmd_x1, cmd_y1);
    assign row_end   = (cur_x == x1_q);
    assign last_px   = row_end && (cur_y == y1_q);
    assign first_row = row_base(cmd_y0);
    assign next_row  = row_q + ROW_STEP;

    always_ff @(posedge write_clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            x0_q   <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            cur_x  <= '0;
            cur_y  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (legal) begin
                            x0_q   <= cmd_x0;
                            x1_q   <= cmd_x1;
                            y1_q   <= cmd_y1;
                            cur_x  <= cmd_x0;
                            cur_y  <= cmd_y0;
                            row_q  <= first_row;
                            addr_q <= first_row
                                    + FB_AW'(cmd_x0);
                            data_q <= cmd_data;
                            we_q   <= 1'b1;
                            state  <= FILL;
                        end else begin
                            err_q  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (last_px) begin
                        we_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (row_end) begin
                        // wrap to the next row: new base plus left column
                        cur_x  <= x0_q;
                        cur_y  <= cur_y + Y_WIDTH'(1);
                        row_q  <= next_row;
                        addr_q <= next_row + FB_AW'(x0_q);
                    end else begin
                        cur_x  <= cur_x + X_WIDTH'(1);
                        addr_q <= addr_q + FB_AW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign we         = we_q;
    assign data       = data_q;
    assign write_addr = ADDR_WIDTH'(addr_q);

endmodule

// File: tb/tb_framebuffer_fill_ctrl.sv
// Self-checking bench for framebuffer_fill_ctrl.
// Table of fill commands with hand-computed results, plus reset-abort and held-valid sequences.
module tb_framebuffer_fill_ctrl;

    localparam int DW = 1;
    localparam int AW = 15;

    logic          write_clock;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_x0;
    logic [6:0]    cmd_y0;
    logic [7:0]    cmd_x1;
    logic [6:0]    cmd_y1;
    logic [DW-1:0] cmd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] data;
    logic          we;

    framebuffer_fill_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .write_clock(write_clock),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x0     (cmd_x0),
        .cmd_y0     (cmd_y0),
        .cmd_x1     (cmd_x1),
        .cmd_y1     (cmd_y1),
        .cmd_data   (cmd_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .write_addr (write_addr),
        .data       (data),
        .we         (we)
    );

    initial write_clock = 1'b0;
    always #5 write_clock = ~write_clock;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
        int dat;
        bit legal;
        int n;
        int first;
        int last;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    bit fb     [0:19199];
    bit exp_fb [0:19199];

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int wr, bad_ord, bad_dat, done_c, err_c, rdy_c;
        int first_a, last_a, prev_a, w, ea, diff;
        wr = 0; bad_ord = 0; bad_dat = 0;
        done_c = 0; err_c = 0; rdy_c = 0;
        first_a = -1; last_a = -1;
        w = v.x1 - v.x0 + 1;
        @(negedge write_clock);
        prev_a = int'(write_addr);
        chk({tag, " ready_before"}, int'(cmd_ready), 1);
        cmd_x0    = 8'(v.x0);
        cmd_y0    = 7'(v.y0);
        cmd_x1    = 8'(v.x1);
        cmd_y1    = 7'(v.y1);
        cmd_data  = DW'(v.dat);
        cmd_valid = 1'b1;
        @(posedge write_clock);
        #1;
        cmd_valid = 1'b0;
        cmd_x0    = 8'($urandom);
        cmd_y0    = 7'($urandom);
        cmd_x1    = 8'($urandom);
        cmd_y1    = 7'($urandom);
        cmd_data  = DW'($urandom);
        for (int k = 1; k <= 20010; k++) begin
            @(negedge write_clock);
            if (we) begin
                ea = v.legal ?
                     (v.y0 + wr / w) * 160 + v.x0 + wr % w : -1;
                if (int'(write_addr) != ea) bad_ord++;
                if (int'(data) != v.dat) bad_dat++;
                if (wr == 0) first_a = int'(write_addr);
                last_a = int'(write_addr);
                if (int'(write_addr) < 19200)
                    fb[int'(write_addr)] = data[0];
                wr++;
            end
            if (done && done_c == 0) done_c = k;
            if (err && err_c == 0) err_c = k;
            if (cmd_ready) begin
                rdy_c = k;
                break;
            end
        end
        chk({tag, " writes"}, wr, v.n);
        chk({tag, " addr_order_errs"}, bad_ord, 0);
        chk({tag, " data_errs"}, bad_dat, 0);
        chk({tag, " done_cycle"}, done_c, v.legal ? v.n + 1 : 0);
        chk({tag, " err_cycle"}, err_c, v.legal ? 0 : 1);
        chk({tag, " ready_cycle"}, rdy_c, v.legal ? v.n + 2 : 1);
        chk({tag, " addr_hold"}, int'(write_addr),
            v.legal ? v.last : prev_a);
        if (v.legal) begin
            chk({tag, " first_addr"}, first_a, v.first);
            chk({tag, " last_addr"}, last_a, v.last);
            for (int y = v.y0; y <= v.y1; y++)
                for (int x = v.x0; x <= v.x1; x++)
                    exp_fb[y * 160 + x] = v.dat[0];
            diff = 0;
            for (int a = 0; a < 19200; a++)
                if (fb[a] != exp_fb[a]) diff++;
            chk({tag, " readback_diffs"}, diff, 0);
        end
    endtask

    vec_t vecs [8];
    vec_t small_v;

    int cnt, nwe, ndone, nerr, nw;
    int h_cyc  [7];
    int h_adr  [7];
    int h_dat  [7];
    int done_a [2];
    int nd;
    int exp_cyc [7];
    int exp_adr [7];
    int exp_dat [7];

    initial begin
        vecs[0] = '{0,   0,   0,   0,   1, 1'b1, 1,     0,     0};
        vecs[1] = '{0,   0,   159, 119, 1, 1'b1, 19200, 0,     19199};
        vecs[2] = '{40,  30,  119, 89,  0, 1'b1, 4800,  4840,  14359};
        vecs[3] = '{0,   0,   160, 0,   1, 1'b0, 0,     0,     0};
        vecs[4] = '{5,   0,   4,   0,   1, 1'b0, 0,     0,     0};
        vecs[5] = '{0,   0,   0,   120, 1, 1'b0, 0,     0,     0};
        vecs[6] = '{159, 119, 159, 119, 0, 1'b1, 1,     19199, 19199};
        vecs[7] = '{10,  5,   12,  8,   0, 1'b1, 12,    810,   1292};
        small_v = '{3,   2,   5,   4,   1, 1'b1, 9,     323,   645};

        exp_cyc = '{1, 2, 3, 6, 7, 8, 9};
        exp_adr = '{1610, 1611, 1612, 3220, 3221, 3380, 3381};
        exp_dat = '{1, 1, 1, 0, 0, 0, 0};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_x1    = '0;
        cmd_y1    = '0;
        cmd_data  = '0;
        #23;
        chk("rst we", int'(we), 0);
        chk("rst write_addr", int'(write_addr), 0);
        chk("rst data", int'(data), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        chk("rst busy", int'(busy), 0);
        @(negedge write_clock);
        reset_n = 1'b1;
        @(negedge write_clock);
        chk("post_rst cmd_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 8; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // reset during a full-screen fill
        @(negedge write_clock);
        cmd_x0 = 8'd0; cmd_y0 = 7'd0;
        cmd_x1 = 8'd159; cmd_y1 = 7'd119;
        cmd_data = 1'b1;
        cmd_valid = 1'b1;
        @(posedge write_clock);
        #1;
        cmd_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge write_clock);
            if (we) cnt++;
            if (cnt == 10) break;
        end
        chk("abort writes_before", cnt, 10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort we", int'(we), 0);
        chk("abort write_addr", int'(write_addr), 0);
        chk("abort done", int'(done), 0);
        chk("abort busy", int'(busy), 0);
        @(negedge write_clock);
        reset_n = 1'b1;
        nwe = 0; ndone = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge write_clock);
            if (k == 0)
                chk("abort ready_after", int'(cmd_ready), 1);
            if (we) nwe++;
            if (done) ndone++;
        end
        chk("abort stray_we", nwe, 0);
        chk("abort stray_done", ndone, 0);
        run_vec(small_v, "after_abort");

        // cmd_valid held high across a fill
        @(negedge write_clock);
        cmd_x0 = 8'd10; cmd_y0 = 7'd10;
        cmd_x1 = 8'd12; cmd_y1 = 7'd10;
        cmd_data = 1'b1;
        cmd_valid = 1'b1;
        @(posedge write_clock);
        #1;
        cmd_x0 = 8'd20; cmd_y0 = 7'd20;
        cmd_x1 = 8'd21; cmd_y1 = 7'd21;
        cmd_data = 1'b0;
        nw = 0; nd = 0; nerr = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge write_clock);
            if (we) begin
                if (nw < 7) begin
                    h_cyc[nw] = k;
                    h_adr[nw] = int'(write_addr);
                    h_dat[nw] = int'(data);
                end
                nw++;
            end
            if (done) begin
                if (nd < 2) done_a[nd] = k;
                nd++;
            end
            if (err) nerr++;
            if (k == 6) cmd_valid = 1'b0;
        end
        chk("held writes", nw, 7);
        chk("held done_count", nd, 2);
        chk("held err_count", nerr, 0);
        if (nd >= 2) begin
            chk("held done1_cycle", done_a[0], 4);
            chk("held done2_cycle", done_a[1], 10);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < nw) begin
                chk($sformatf("held w%0d cycle", i), h_cyc[i], exp_cyc[i]);
                chk($sformatf("held w%0d addr", i), h_adr[i], exp_adr[i]);
                chk($sformatf("held w%0d data", i), h_dat[i], exp_dat[i]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
